mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Initiator-side master for the single-port MEMORY block: drives its addr / r_en / w_en / data_in and samples its data_out.
- Performs block operations on command from a controller:
  - COPY: N words from a source region to a destination region.
  - FILL: N words of a constant pattern into a destination region.
- Sits between the control FSM and the data memory. It is the only memory master while busy.

Parameters:
- ADDR_LEN, 8, memory address width; addresses wrap modulo 2^ADDR_LEN.
- WORD_LEN, 8, memory word width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- op  input  1  0 = COPY, 1 = FILL; latched on accepted start.
- src_addr  input  ADDR_LEN  COPY source base; latched on start.
- dst_addr  input  ADDR_LEN  destination base; latched on start.
- len  input  ADDR_LEN+1  word count, 0..2^ADDR_LEN; latched on start.
- pattern  input  WORD_LEN  FILL value; latched on start.
- busy  output  1  high from the cycle after an accepted start until the DONE cycle (exclusive).
- done  output  1  one-cycle pulse when the command completes.
- mem_addr  output  ADDR_LEN  to MEMORY addr.
- mem_r_en  output  1  to MEMORY r_en.
- mem_w_en  output  1  to MEMORY w_en.
- mem_wdata  output  WORD_LEN  to MEMORY data_in.
- mem_rdata  input  WORD_LEN  from MEMORY data_out; combinational read, valid in the same cycle as r_en/addr.

Behaviour:
- State registers: state, idx (ADDR_LEN+1 bits), latched command fields, rbuf (WORD_LEN).
- FSM states: IDLE, READ, WRITE, DONE.
- All outputs decode only from registered state. There is no combinational path from start/op/len/etc. to any output.
- Reset (rst_n low, asynchronous):
  - state = IDLE, idx = 0, rbuf = 0.
  - busy = done = mem_r_en = mem_w_en = 0; mem_addr = 0; mem_wdata = 0.
- Reset mid-operation aborts immediately. A partially completed copy is left as-is; no done pulse.
- IDLE:
  - All memory outputs are 0.
  - On an edge with start=1: latch fields, clear idx, then transition:
    - len == 0 -> DONE.
    - op == COPY -> READ.
    - op == FILL -> WRITE.
- READ (COPY only):
  - Drives mem_addr = src + idx (mod 2^ADDR_LEN), mem_r_en = 1, mem_w_en = 0.
  - At the edge, rbuf <= mem_rdata, then -> WRITE.
- WRITE:
  - Drives mem_addr = dst + idx (mod 2^ADDR_LEN) and mem_w_en = 1, mem_r_en = 0.
  - mem_wdata = rbuf for COPY, latched pattern for FILL.
  - At the edge, idx <= idx + 1. Then -> DONE if idx + 1 == len, else -> READ (COPY) or WRITE (FILL).
- DONE: done = 1, busy = 0, memory controls 0; next state IDLE.
- busy = 1 exactly in READ and WRITE.
- mem_r_en and mem_w_en are never high together.
- Latency, counting cycles after the accepting edge:
  - COPY of N words: 2N memory cycles; done in cycle 2N+1.
  - FILL of N words: N cycles; done in cycle N+1.
  - len = 0: done in cycle 1 with no memory access.
- start while not IDLE (including DONE) is ignored; inputs may change freely after acceptance.
- Back-to-back commands: earliest new acceptance is the IDLE cycle following DONE.
- Address wrap: base + idx past 2^ADDR_LEN-1 wraps to 0. len = 2^ADDR_LEN touches every location once.
- Overlap: copy runs strictly ascending. With dst in (src, src+len) the source is overwritten before it is read; this is the defined result and is not detected.
- src == dst COPY rewrites each word with itself; contents are unchanged.

Test Plan:
- Preload mem[0x10..0x13] = A1,B2,C3,D4; COPY src=0x10 dst=0x40 len=4 -> mem[0x40..0x43] = A1,B2,C3,D4; done in cycle 9; busy high in cycles 1..8; r_en/w_en alternate starting with r_en.
- FILL dst=0xFE len=4 pattern=0x5A -> mem[0xFE], mem[0xFF], mem[0x00], mem[0x01] = 5A; done in cycle 5; mem_addr sequence FE,FF,00,01.
- COPY len=0 -> no r_en/w_en ever asserted; done in cycle 1; memory unchanged.
- Overlap COPY src=0x20 dst=0x21 len=3 with mem[0x20..0x23] = 01,02,03,04 -> final mem[0x21..0x23] = 01,01,01.
- Pulse start repeatedly during a len=8 COPY -> only one done; a second command is accepted only in IDLE after DONE.
- Assert rst_n=0 in cycle 3 of a len=4 COPY -> all outputs 0 asynchronously; only mem[dst] written; no done; a new FILL then completes normally.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Block-copy / block-fill master for the single-port data memory.
// Runs one COPY or FILL command at a time and drives the memory handshake from registered state only.
module mem_copy_engine #(
  parameter int ADDR_LEN = 8,
  parameter int WORD_LEN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op,
  input  logic [ADDR_LEN-1:0] src_addr,
  input  logic [ADDR_LEN-1:0] dst_addr,
  input  logic [ADDR_LEN:0]   len,
  input  logic [WORD_LEN-1:0] pattern,
  output logic                busy,
  output logic                done,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_r_en,
  output logic                mem_w_en,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

  logic [1:0]          state;
  logic [ADDR_LEN:0]   idx;
  logic [ADDR_LEN:0]   idx_next;
  logic                op_q;
  logic [ADDR_LEN-1:0] src_q;
  logic [ADDR_LEN-1:0] dst_q;
  logic [ADDR_LEN:0]   len_q;
  logic [WORD_LEN-1:0] pattern_q;
  logic [WORD_LEN-1:0] rbuf;

  assign idx_next = idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      op_q      <= OP_COPY;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      pattern_q <= '0;
      rbuf      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            src_q     <= src_addr;
            dst_q     <= dst_addr;
            len_q     <= len;
            pattern_q <= pattern;
            idx       <= '0;
            if (len == '0)
              state <= DONE;
            else if (op == OP_FILL)
              state <= WRITE;
            else
              state <= READ;
          end
        end
        READ: begin
          rbuf  <= mem_rdata;
          state <= WRITE;
        end
        WRITE: begin
          idx <= idx_next;
          // idx is one bit wider than an address so len = 2^ADDR_LEN terminates.
          if (idx_next == len_q)
            state <= DONE;
          else if (op_q == OP_FILL)
            state <= WRITE;
          else
            state <= READ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    mem_wdata = '0;
    case (state)
      READ: begin
        busy     = 1'b1;
        mem_r_en = 1'b1;
        mem_addr = src_q + idx[ADDR_LEN-1:0];
      end
      WRITE: begin
        busy      = 1'b1;
        mem_w_en  = 1'b1;
        mem_addr  = dst_q + idx[ADDR_LEN-1:0];
        mem_wdata = (op_q == OP_FILL) ? pattern_q : rbuf;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a behavioural memory plus a per-cycle expected-output queue built
// from the command semantics (ascending word-by-word copy/fill), compared every cycle.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       op;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [8:0] len;
  logic [7:0] pattern;
  logic       busy;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_r_en;
  logic       mem_w_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  mem_copy_engine #(.ADDR_LEN(8), .WORD_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .pattern(pattern),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       r_en;
    logic       w_en;
    logic [7:0] addr;
    logic [7:0] wdata;
  } obs_t;

  logic [7:0] mem    [256];
  logic [7:0] refmem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_a  = '0;
  logic [7:0] pre_d  = '0;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (mem_w_en) mem[mem_addr] <= mem_wdata;
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_lat = 0;
  obs_t exp_q[$];
  obs_t act_o, exp_o;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic obs_t mk(input logic b, input logic d, input logic r, input logic w,
                              input logic [7:0] a, input logic [7:0] wd);
    obs_t o;
    o = '{busy: b, done: d, r_en: r, w_en: w, addr: a, wdata: wd};
    return o;
  endfunction

  // Outside a command every output must be zero.
  always @(negedge clk) begin
    act_o = {busy, done, mem_r_en, mem_w_en, mem_addr, mem_wdata};
    if (exp_q.size() > 0) exp_o = exp_q.pop_front();
    else exp_o = '0;
    chk("outputs", 32'(act_o), 32'(exp_o));
    if (done) last_lat = cyc - acc_cyc + 1;
  end

  // Expected cycle trace; only the first `limit` cycles are queued and their writes applied.
  task automatic gen(input bit o, input logic [7:0] s, input logic [7:0] d, input int n,
                     input logic [7:0] p, input int limit);
    int e = 0;
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      if (!o) begin
        v = refmem[8'(s + i)];
        if (e < limit) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'(s + i), 8'h00));
        e++;
      end else begin
        v = p;
      end
      if (e < limit) begin
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'(d + i), v));
        refmem[8'(d + i)] = v;
      end
      e++;
    end
    if (e < limit) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00));
  endtask

  task automatic scramble();
    op       = 1'($urandom);
    src_addr = 8'($urandom);
    dst_addr = 8'($urandom);
    len      = 9'($urandom);
    pattern  = 8'($urandom);
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    refmem[a] = d;
  endtask

  task automatic wait_idle();
    int b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      @(posedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      chk("timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic mem_check(input string name);
    int bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== refmem[i]) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  task automatic run_cmd(input bit o, input logic [7:0] s, input logic [7:0] d, input int n,
                         input logic [7:0] p, input bit pulse);
    int t;
    @(posedge clk); #1;
    start = 1'b1; op = o; src_addr = s; dst_addr = d; len = 9'(n); pattern = p;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start = 1'b0;
    scramble();
    gen(o, s, d, n, p, 1 << 20);
    if (pulse) begin
      t = exp_q.size();
      for (int c = 0; c < t; c++) begin
        start = 1'($urandom);
        scramble();
        @(posedge clk); #1;
      end
      start = 1'b0;
    end
    wait_idle();
    mem_check("mem_contents");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0;
    op = 1'b0; src_addr = '0; dst_addr = '0; len = '0; pattern = '0;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    chk("reset_outputs", 32'({busy, done, mem_r_en, mem_w_en, mem_addr, mem_wdata}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
    run_cmd(1'b0, 8'h10, 8'h40, 4, 8'h00, 1'b0);
    chk("copy4_latency", 32'(last_lat), 32'd9);
    chk("copy4_w0", 32'(mem[8'h40]), 32'hA1);
    chk("copy4_w1", 32'(mem[8'h41]), 32'hB2);
    chk("copy4_w2", 32'(mem[8'h42]), 32'hC3);
    chk("copy4_w3", 32'(mem[8'h43]), 32'hD4);

    run_cmd(1'b1, 8'h00, 8'hFE, 4, 8'h5A, 1'b0);
    chk("fill4_latency", 32'(last_lat), 32'd5);
    chk("fill_wrap_fe", 32'(mem[8'hFE]), 32'h5A);
    chk("fill_wrap_ff", 32'(mem[8'hFF]), 32'h5A);
    chk("fill_wrap_00", 32'(mem[8'h00]), 32'h5A);
    chk("fill_wrap_01", 32'(mem[8'h01]), 32'h5A);

    run_cmd(1'b0, 8'h33, 8'h77, 0, 8'h00, 1'b0);
    chk("len0_latency", 32'(last_lat), 32'd1);

    poke(8'h20, 8'h01); poke(8'h21, 8'h02); poke(8'h22, 8'h03); poke(8'h23, 8'h04);
    run_cmd(1'b0, 8'h20, 8'h21, 3, 8'h00, 1'b0);
    chk("overlap_21", 32'(mem[8'h21]), 32'h01);
    chk("overlap_22", 32'(mem[8'h22]), 32'h01);
    chk("overlap_23", 32'(mem[8'h23]), 32'h01);

    run_cmd(1'b0, 8'h80, 8'hC0, 8, 8'h00, 1'b1);
    chk("pulsed_copy_latency", 32'(last_lat), 32'd17);
    run_cmd(1'b1, 8'h00, 8'hD0, 3, 8'h3C, 1'b0);

    // Reset lands in cycle 3 of a 4-word copy: only the first word was written.
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; src_addr = 8'h60; dst_addr = 8'h90; len = 9'd4; pattern = 8'h00;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start = 1'b0;
    gen(1'b0, 8'h60, 8'h90, 4, 8'h00, 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("reset_async", 32'({busy, done, mem_r_en, mem_w_en, mem_addr, mem_wdata}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_idle();
    mem_check("mem_after_reset");
    run_cmd(1'b1, 8'h00, 8'h90, 4, 8'hE7, 1'b0);
    chk("fill_after_reset", 32'(mem[8'h93]), 32'hE7);

    run_cmd(1'b0, 8'h50, 8'h50, 6, 8'h00, 1'b0);
    run_cmd(1'b1, 8'h00, 8'h37, 256, 8'h99, 1'b0);
    chk("fill256_latency", 32'(last_lat), 32'd257);
    run_cmd(1'b0, 8'h12, 8'h34, 256, 8'h00, 1'b0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0: n = 0;
        1: n = 256;
        default: n = int'($urandom_range(1, 12));
      endcase
      run_cmd(1'($urandom), 8'($urandom), 8'($urandom), n, 8'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
